aixh_mxc_upper_qfeed: RTL and testbench

AIXH_MXC_UPPER_QFEED -- requirements
Module: AIXH_MXC_UPPER_qfeed

---
 rtl/aixh_mxc_upper_qfeed_if.sv | 37 +++
 rtl/aixh_mxc_upper_qfeed.sv | 165 ++++++++++++++++
 tb/tb_aixh_mxc_upper_qfeed.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/aixh_mxc_upper_qfeed_if.sv
// ---------------------------------------------------------------------------
// aixh_mxc_upper_qfeed_if
// Purpose : bundles the burst control, upstream vector handshake and the
//           queue-tile write port of aixh_mxc_upper_qfeed.
// Signals : i_start/i_len/i_cell_mask  burst request
//           i_vld/i_dat/o_rdy          upstream vector handshake
//           i_hold                     queue-tile stall
//           o_utc_vld/o_utc_dat        per-cell queue-tile write port
//           o_busy/o_done              burst status
// Modports: master drives the i_* side, slave (the feeder) drives o_*.
// ---------------------------------------------------------------------------
interface aixh_mxc_upper_qfeed_if #(
  parameter int UQTILE_CELLS      = 4,
  parameter int UQCELL_DWD_DWIDTH = 8
);
  logic                                      i_start;
  logic [15:0]                               i_len;
  logic [UQTILE_CELLS-1:0]                   i_cell_mask;
  logic                                      i_vld;
  logic [UQTILE_CELLS*UQCELL_DWD_DWIDTH-1:0] i_dat;
  logic                                      o_rdy;
  logic                                      i_hold;
  logic [UQTILE_CELLS-1:0]                   o_utc_vld;
  logic [UQTILE_CELLS*UQCELL_DWD_DWIDTH-1:0] o_utc_dat;
  logic                                      o_busy;
  logic                                      o_done;

  modport master (
    output i_start, i_len, i_cell_mask, i_vld, i_dat, i_hold,
    input  o_rdy, o_utc_vld, o_utc_dat, o_busy, o_done
  );

  modport slave (
    input  i_start, i_len, i_cell_mask, i_vld, i_dat, i_hold,
    output o_rdy, o_utc_vld, o_utc_dat, o_busy, o_done
  );
endinterface

// File: rtl/aixh_mxc_upper_qfeed.sv
// ---------------------------------------------------------------------------
// aixh_mxc_upper_qfeed
// Purpose : accepts a burst of i_len upstream vectors, stages them in a small
//           FIFO and replays them to the queue tile with disabled cells
//           zeroed. Output stage is registered (accept N -> output N+2).
// Ports   : aixh_core_clk  sole clock, rising edge
//           aixh_core_rst  asynchronous active-high reset
//           bus            aixh_mxc_upper_qfeed_if.slave (see interface file)
// Params  : TILE_INDEX informational only; FIFO_DEPTH power of two >= 2.
// ---------------------------------------------------------------------------
module aixh_mxc_upper_qfeed #(
  parameter int TILE_INDEX        = 0,
  parameter int FIFO_DEPTH        = 4,
  parameter int UQTILE_CELLS      = 4,
  parameter int UQCELL_DWD_DWIDTH = 8
) (
  input logic                   aixh_core_clk,
  input logic                   aixh_core_rst,
  aixh_mxc_upper_qfeed_if.slave bus
);
  localparam int DW = UQTILE_CELLS * UQCELL_DWD_DWIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  // Zero every cell slice whose enable bit is clear.
  function automatic logic [DW-1:0] f_cell_gate(input logic [DW-1:0] dat,
                                                input logic [UQTILE_CELLS-1:0] mask);
    logic [DW-1:0] g;
    g = '0;
    for (int c = 0; c < UQTILE_CELLS; c++) begin
      if (mask[c]) begin
        g[c*UQCELL_DWD_DWIDTH +: UQCELL_DWD_DWIDTH] = dat[c*UQCELL_DWD_DWIDTH +: UQCELL_DWD_DWIDTH];
      end else begin
        g[c*UQCELL_DWD_DWIDTH +: UQCELL_DWD_DWIDTH] = '0;
      end
    end
    return g;
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [15:0]             r_len;
  logic [15:0]             r_acc_cnt;
  logic [UQTILE_CELLS-1:0] r_mask;
  logic [DW-1:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [CW-1:0]           w_count_nxt;
  logic [UQTILE_CELLS-1:0] r_utc_vld;
  logic [DW-1:0]           r_utc_dat;
  logic                    r_pend;
  logic                    r_done;
  logic                    w_done_nxt;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_rdy;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_start_burst;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == {CW{1'b0}});
  // Ready is a pure decode of registered state; i_vld never feeds back.
  assign w_rdy   = (r_state == S_STREAM) && !w_full && (r_acc_cnt < r_len);
  assign w_push  = bus.i_vld && w_rdy;
  assign w_pop   = !w_empty && !bus.i_hold;
  assign w_start_burst = (r_state == S_IDLE) && bus.i_start && (bus.i_len != 16'd0);

  // Next-state decode of the burst FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_burst) w_state_nxt = S_STREAM;
        else               w_state_nxt = S_IDLE;
      end
      S_STREAM: begin
        if (w_push && ((r_acc_cnt + 16'd1) == r_len)) w_state_nxt = S_DRAIN;
        else                                          w_state_nxt = S_STREAM;
      end
      S_DRAIN: begin
        // r_pend marks an entry sitting in the output stage this cycle.
        if (w_empty && !r_pend) w_state_nxt = S_IDLE;
        else                    w_state_nxt = S_DRAIN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO occupancy and the registered done pulse.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    // o_done is registered one cycle early: it is set for the DRAIN cycle in
    // which both FIFO and output stage will be empty, i.e. the exit cycle.
    if ((r_state == S_IDLE) && bus.i_start && (bus.i_len == 16'd0)) begin
      w_done_nxt = 1'b1;
    end else if ((w_state_nxt == S_DRAIN) && (w_count_nxt == {CW{1'b0}}) && !w_pop) begin
      w_done_nxt = 1'b1;
    end else begin
      w_done_nxt = 1'b0;
    end
  end

  // State, burst registers, pointers and output stage.
  always_ff @(posedge aixh_core_clk or posedge aixh_core_rst) begin
    if (aixh_core_rst) begin
      r_state   <= S_IDLE;
      r_len     <= 16'd0;
      r_acc_cnt <= 16'd0;
      r_mask    <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_utc_vld <= '0;
      r_utc_dat <= '0;
      r_pend    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
      r_pend  <= w_pop;
      if (w_start_burst) begin
        r_len     <= bus.i_len;
        r_mask    <= bus.i_cell_mask;
        r_acc_cnt <= 16'd0;
      end else if (w_push) begin
        r_acc_cnt <= r_acc_cnt + 16'd1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_utc_vld <= r_mask;
        r_utc_dat <= f_cell_gate(r_mem[r_rd_ptr], r_mask);
      end else begin
        r_utc_vld <= '0;
        r_utc_dat <= '0;
      end
    end
  end

  // FIFO storage; occupancy and pointers define validity, so no reset.
  always_ff @(posedge aixh_core_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.i_dat;
  end

  assign bus.o_rdy     = w_rdy;
  assign bus.o_utc_vld = r_utc_vld;
  assign bus.o_utc_dat = r_utc_dat;
  assign bus.o_busy    = (r_state != S_IDLE);
  assign bus.o_done    = r_done;
endmodule

// File: tb/tb_aixh_mxc_upper_qfeed.sv
// ---------------------------------------------------------------------------
// tb_aixh_mxc_upper_qfeed
// Purpose : directed self-checking bench for aixh_mxc_upper_qfeed with
//           4 cells x 8 bits and a 4-entry FIFO.
// ---------------------------------------------------------------------------
module tb_aixh_mxc_upper_qfeed;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  aixh_mxc_upper_qfeed_if #(.UQTILE_CELLS(4), .UQCELL_DWD_DWIDTH(8)) bif ();

  aixh_mxc_upper_qfeed #(
    .TILE_INDEX(0), .FIFO_DEPTH(4), .UQTILE_CELLS(4), .UQCELL_DWD_DWIDTH(8)
  ) dut (
    .aixh_core_clk(clk),
    .aixh_core_rst(rst),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat(input int k);
    return 32'hA0B0C0D0 + 32'(k) * 32'h01010101;
  endfunction

  function automatic logic [31:0] gate(input logic [31:0] d, input logic [3:0] m);
    logic [31:0] e;
    for (int c = 0; c < 4; c++) e[c*8 +: 8] = {8{m[c]}};
    return d & e;
  endfunction

  // Runs one burst and scores every output beat against the expected stream.
  task automatic burst(input string tag, input int len, input logic [3:0] mask,
                       input int base, input int hold_cyc, input bit poke);
    int acc, outn, dones;
    bit fin, accepted;
    acc = 0; outn = 0; dones = 0; fin = 1'b0;
    bif.i_start = 1'b1; bif.i_len = 16'(len); bif.i_cell_mask = mask;
    tick();
    bif.i_start = 1'b0;
    for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
      if (bif.o_utc_vld != 4'd0 || bif.o_utc_dat != 32'd0) begin
        chk({tag, "_vld"}, 64'(bif.o_utc_vld), 64'(mask));
        chk({tag, "_dat"}, 64'(bif.o_utc_dat), 64'(gate(pat(base + outn), mask)));
        outn++;
      end
      if (bif.o_done) dones++;
      if (dones > 0 && !bif.o_busy) fin = 1'b1;
      if (hold_cyc > 0 && cyc == hold_cyc) begin
        chk({tag, "_hold_acc"}, 64'(acc), 64'd4);
        chk({tag, "_hold_rdy"}, 64'(bif.o_rdy), 64'd0);
      end
      bif.i_hold  = (cyc < hold_cyc);
      bif.i_start = poke && (cyc == 1);
      if (poke) begin
        bif.i_len = 16'd9; bif.i_cell_mask = 4'b0000;
      end
      bif.i_vld = (acc < len);
      bif.i_dat = pat(base + acc);
      accepted  = bif.i_vld && bif.o_rdy;
      tick();
      if (accepted) acc++;
    end
    bif.i_vld = 1'b0; bif.i_start = 1'b0; bif.i_hold = 1'b0;
    chk({tag, "_outs"}, 64'(outn), 64'(len));
    chk({tag, "_accs"}, 64'(acc), 64'(len));
    chk({tag, "_dones"}, 64'(dones), 64'd1);
    chk({tag, "_fin"}, 64'(fin), 64'd1);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1;
    bif.i_start = 1'b0; bif.i_len = 16'd0; bif.i_cell_mask = 4'd0;
    bif.i_vld = 1'b0; bif.i_dat = 32'd0; bif.i_hold = 1'b0;
    #2;
    chk("rst_rdy",  64'(bif.o_rdy), 64'd0);
    chk("rst_busy", 64'(bif.o_busy), 64'd0);
    chk("rst_done", 64'(bif.o_done), 64'd0);
    chk("rst_vld",  64'(bif.o_utc_vld), 64'd0);
    chk("rst_dat",  64'(bif.o_utc_dat), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Three-vector burst: latency, order and done timing.
    bif.i_start = 1'b1; bif.i_len = 16'd3; bif.i_cell_mask = 4'hF;
    tick();
    bif.i_start = 1'b0;
    chk("b3_busy", 64'(bif.o_busy), 64'd1);
    chk("b3_rdy",  64'(bif.o_rdy), 64'd1);
    bif.i_vld = 1'b1; bif.i_dat = 32'h11223344;
    tick();
    chk("b3_lat_vld", 64'(bif.o_utc_vld), 64'd0);
    bif.i_dat = 32'h55667788;
    tick();
    chk("b3_a_vld", 64'(bif.o_utc_vld), 64'hF);
    chk("b3_a_dat", 64'(bif.o_utc_dat), 64'h11223344);
    bif.i_dat = 32'h99AABBCC;
    tick();
    chk("b3_b_dat", 64'(bif.o_utc_dat), 64'h55667788);
    chk("b3_b_vld", 64'(bif.o_utc_vld), 64'hF);
    chk("b3_rdy_end", 64'(bif.o_rdy), 64'd0);
    bif.i_vld = 1'b0;
    tick();
    chk("b3_c_dat", 64'(bif.o_utc_dat), 64'h99AABBCC);
    chk("b3_c_done", 64'(bif.o_done), 64'd0);
    tick();
    chk("b3_done", 64'(bif.o_done), 64'd1);
    chk("b3_done_busy", 64'(bif.o_busy), 64'd1);
    chk("b3_done_vld", 64'(bif.o_utc_vld), 64'd0);
    tick();
    chk("b3_done_off", 64'(bif.o_done), 64'd0);
    chk("b3_idle", 64'(bif.o_busy), 64'd0);

    // Partial cell mask with all-ones data.
    bif.i_start = 1'b1; bif.i_len = 16'd1; bif.i_cell_mask = 4'b0101;
    tick();
    bif.i_start = 1'b0;
    bif.i_vld = 1'b1; bif.i_dat = 32'hFFFFFFFF;
    tick();
    bif.i_vld = 1'b0;
    tick();
    chk("msk_vld", 64'(bif.o_utc_vld), 64'h5);
    chk("msk_dat", 64'(bif.o_utc_dat), 64'h00FF00FF);
    tick();
    chk("msk_done", 64'(bif.o_done), 64'd1);
    tick();
    chk("msk_idle", 64'(bif.o_busy), 64'd0);

    // Zero-length start.
    bif.i_start = 1'b1; bif.i_len = 16'd0; bif.i_cell_mask = 4'hF;
    tick();
    bif.i_start = 1'b0;
    chk("z_done", 64'(bif.o_done), 64'd1);
    chk("z_busy", 64'(bif.o_busy), 64'd0);
    chk("z_vld",  64'(bif.o_utc_vld), 64'd0);
    tick();
    chk("z_done_off", 64'(bif.o_done), 64'd0);
    chk("z_busy2", 64'(bif.o_busy), 64'd0);

    // Stall with full FIFO, then release.
    burst("hold", 6, 4'hF, 40, 10, 1'b0);
    // Start during a burst is ignored.
    burst("poke", 3, 4'b1010, 60, 0, 1'b1);

    // Reset after two accepts of a five-vector burst.
    bif.i_start = 1'b1; bif.i_len = 16'd5; bif.i_cell_mask = 4'hF;
    tick();
    bif.i_start = 1'b0;
    bif.i_vld = 1'b1; bif.i_dat = pat(0);
    tick();
    bif.i_dat = pat(1);
    tick();
    bif.i_vld = 1'b0;
    chk("mr_pre_vld", 64'(bif.o_utc_vld), 64'hF);
    #1 rst = 1'b1;
    #1;
    chk("mr_vld",  64'(bif.o_utc_vld), 64'd0);
    chk("mr_dat",  64'(bif.o_utc_dat), 64'd0);
    chk("mr_rdy",  64'(bif.o_rdy), 64'd0);
    chk("mr_busy", 64'(bif.o_busy), 64'd0);
    chk("mr_done", 64'(bif.o_done), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("mr_post_done", 64'(bif.o_done), 64'd0);
    chk("mr_post_vld",  64'(bif.o_utc_vld), 64'd0);
    tick();
    chk("mr_post_busy", 64'(bif.o_busy), 64'd0);
    burst("fresh", 1, 4'hF, 80, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
